// File: rtl/match_controller_pkg.sv
// match_controller_pkg: phase and winner encodings shared by the match controller files.
package match_controller_pkg;
    localparam int HEALTH_W = 9;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_INTRO      = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_ROUND_END  = 3'd3,
        PH_MATCH_OVER = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        W_NONE = 2'd0,
        W_P1   = 2'd1,
        W_P2   = 2'd2,
        W_DRAW = 2'd3
    } winner_t;

    function automatic winner_t leader(input logic [HEALTH_W-1:0] a, input logic [HEALTH_W-1:0] b,
                                       input winner_t tie);
        return a > b ? W_P1 : a < b ? W_P2 : tie;
    endfunction
endpackage

// File: rtl/match_controller_sec_timer.sv
// match_controller_sec_timer: game-second divider plus a seconds counter that restarts on clear.
module match_controller_sec_timer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int SEC_W = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic sec_tick,
    output logic [SEC_W-1:0] sec_cnt
);
    localparam int TICK_W = $clog2(TICKS_PER_SEC + 1);

    logic [TICK_W-1:0] tick_cnt;

    assign sec_tick = enable && tick_cnt == TICK_W'(TICKS_PER_SEC - 1);

    always_ff @(posedge clk)
        if (reset || clear) tick_cnt <= '0;
        else if (enable) tick_cnt <= sec_tick ? '0 : tick_cnt + TICK_W'(1);

    always_ff @(posedge clk)
        if (reset || clear) sec_cnt <= '0;
        else if (sec_tick) sec_cnt <= sec_cnt + SEC_W'(1);
endmodule

// File: rtl/match_controller.sv
// match_controller: round/match sequencer with best-of-N scoring.
// Define SUDDEN_DEATH_EN to keep an equal-health timeout in FIGHT until health differs.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int INTRO_SECS    = 3,
    parameter int ROUND_SECS    = 60,
    parameter int KO_HOLD_SECS  = 2,
    parameter int WINS_TO_MATCH = 2,
    parameter int MAX_ROUNDS    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [HEALTH_W-1:0] health_1,
    input  logic [HEALTH_W-1:0] health_2,
    output logic                health_rst,
    output logic                fight_en,
    output logic [2:0]          phase,
    output logic [2:0]          round_num,
    output logic [1:0]          wins_1,
    output logic [1:0]          wins_2,
    output logic [6:0]          time_left,
    output logic [1:0]          round_winner,
    output logic [1:0]          match_winner
);
`ifdef SUDDEN_DEATH_EN
    localparam winner_t TIMEOUT_TIE = W_NONE;
`else
    localparam winner_t TIMEOUT_TIE = W_DRAW;
`endif

    phase_t state, state_next;
    winner_t result;
    logic start_prev, start_rise, sec_tick, phase_done, fight_exit, match_end;
    logic new_match, next_round, enter_intro, enter_over;
    logic [6:0] sec_cnt, hold_secs;

    match_controller_sec_timer #(.TICKS_PER_SEC(TICKS_PER_SEC), .SEC_W(7)) timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_next != state),
        .enable   (state inside {PH_INTRO, PH_FIGHT, PH_ROUND_END}),
        .sec_tick (sec_tick),
        .sec_cnt  (sec_cnt)
    );

    assign phase    = state;
    assign fight_en = state == PH_FIGHT;

    always_comb begin
        start_rise  = start && !start_prev;
        hold_secs   = state == PH_INTRO ? 7'(INTRO_SECS) : 7'(KO_HOLD_SECS);
        phase_done  = sec_tick && sec_cnt == hold_secs - 7'd1;
        result      = health_1 == '0 && health_2 == '0 ? W_DRAW
                    : health_2 == '0 ? W_P1
                    : health_1 == '0 ? W_P2
                    : time_left == '0 ? leader(health_1, health_2, TIMEOUT_TIE) : W_NONE;
        fight_exit  = state == PH_FIGHT && result != W_NONE;
        match_end   = wins_1 == 2'(WINS_TO_MATCH) || wins_2 == 2'(WINS_TO_MATCH) || round_num == 3'(MAX_ROUNDS);
        new_match   = (state == PH_IDLE || state == PH_MATCH_OVER) && start_rise;
        next_round  = state == PH_ROUND_END && phase_done && !match_end;
        enter_over  = state == PH_ROUND_END && phase_done && match_end;
        enter_intro = new_match || next_round;
        state_next  = enter_intro ? PH_INTRO
                    : state == PH_INTRO && phase_done ? PH_FIGHT
                    : fight_exit ? PH_ROUND_END
                    : enter_over ? PH_MATCH_OVER : state;
    end

    always_ff @(posedge clk) state <= reset ? PH_IDLE : state_next;

    always_ff @(posedge clk) start_prev <= reset ? 1'b0 : start;

    // Refill pulse on reset and on every INTRO entry; health is ignored in INTRO to absorb it.
    always_ff @(posedge clk) health_rst <= reset || enter_intro;

    always_ff @(posedge clk)
        if (reset) round_num <= '0;
        else if (new_match) round_num <= 3'd1;
        else if (next_round) round_num <= round_num + 3'd1;

    always_ff @(posedge clk)
        if (reset || new_match) begin
            wins_1 <= '0;
            wins_2 <= '0;
        end else if (fight_exit) begin
            if (result == W_P1 && wins_1 != 2'd3) wins_1 <= wins_1 + 2'd1;
            if (result == W_P2 && wins_2 != 2'd3) wins_2 <= wins_2 + 2'd1;
        end

    always_ff @(posedge clk)
        if (reset) time_left <= '0;
        else if (enter_intro) time_left <= 7'(ROUND_SECS);
        else if (state == PH_FIGHT && sec_tick && time_left != '0) time_left <= time_left - 7'd1;

    always_ff @(posedge clk)
        if (reset || enter_intro) round_winner <= W_NONE;
        else if (fight_exit) round_winner <= result;

    always_ff @(posedge clk)
        if (reset || new_match) match_winner <= W_NONE;
        else if (enter_over) match_winner <= leader(HEALTH_W'(wins_1), HEALTH_W'(wins_2), W_DRAW);
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed bench for match_controller with a 4-cycle game second.
module tb_match_controller;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [8:0] health_1 = 9'd300, health_2 = 9'd300;
    logic health_rst, fight_en;
    logic [2:0] phase, round_num;
    logic [1:0] wins_1, wins_2, round_winner, match_winner;
    logic [6:0] time_left;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    match_controller #(
        .TICKS_PER_SEC(4), .INTRO_SECS(1), .ROUND_SECS(3),
        .KO_HOLD_SECS(1), .WINS_TO_MATCH(2), .MAX_ROUNDS(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .health_1(health_1), .health_2(health_2),
        .health_rst(health_rst), .fight_en(fight_en), .phase(phase), .round_num(round_num),
        .wins_1(wins_1), .wins_2(wins_2), .time_left(time_left),
        .round_winner(round_winner), .match_winner(match_winner)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(1);
        checks++; if (phase !== 3'd0) $display("FAIL reset_phase: got %0d want 0", phase); else passed++;
        checks++; if (health_rst !== 1'b1) $display("FAIL reset_health_rst: got %0b want 1", health_rst); else passed++;
        checks++; if ({fight_en, round_num, wins_1, wins_2, time_left, round_winner, match_winner} !== 19'd0)
            $display("FAIL reset_outputs: got %h want 0", {fight_en, round_num, wins_1, wins_2, time_left, round_winner, match_winner}); else passed++;
        reset = 1'b0;
        step(1);
        checks++; if (health_rst !== 1'b0) $display("FAIL reset_rst_release: got %0b want 0", health_rst); else passed++;
    endtask

    task automatic test_start;
        start = 1'b1;
        step(1);
        checks++; if (phase !== 3'd1) $display("FAIL start_phase: got %0d want 1", phase); else passed++;
        checks++; if (health_rst !== 1'b1) $display("FAIL start_health_rst: got %0b want 1", health_rst); else passed++;
        checks++; if (round_num !== 3'd1) $display("FAIL start_round: got %0d want 1", round_num); else passed++;
        checks++; if (time_left !== 7'd3) $display("FAIL start_time: got %0d want 3", time_left); else passed++;
        start = 1'b0;
        step(1);
        checks++; if (health_rst !== 1'b0) $display("FAIL start_rst_one_cycle: got %0b want 0", health_rst); else passed++;
        step(2);
        checks++; if (phase !== 3'd1) $display("FAIL intro_hold: got %0d want 1", phase); else passed++;
        step(1);
        checks++; if (phase !== 3'd2) $display("FAIL fight_phase: got %0d want 2", phase); else passed++;
        checks++; if (fight_en !== 1'b1) $display("FAIL fight_en: got %0b want 1", fight_en); else passed++;
        checks++; if (time_left !== 7'd3) $display("FAIL fight_time: got %0d want 3", time_left); else passed++;
    endtask

    task automatic test_ko;
        health_1 = 9'd200;
        health_2 = 9'd0;
        step(1);
        checks++; if (phase !== 3'd3) $display("FAIL ko_phase: got %0d want 3", phase); else passed++;
        checks++; if (round_winner !== 2'd1) $display("FAIL ko_winner: got %0d want 1", round_winner); else passed++;
        checks++; if (wins_1 !== 2'd1) $display("FAIL ko_wins_1: got %0d want 1", wins_1); else passed++;
        checks++; if (fight_en !== 1'b0) $display("FAIL ko_fight_en: got %0b want 0", fight_en); else passed++;
        health_1 = 9'd300;
        health_2 = 9'd300;
        step(3);
        checks++; if (phase !== 3'd3) $display("FAIL ko_hold: got %0d want 3", phase); else passed++;
        step(1);
        checks++; if (phase !== 3'd1) $display("FAIL next_intro: got %0d want 1", phase); else passed++;
        checks++; if (round_num !== 3'd2) $display("FAIL next_round: got %0d want 2", round_num); else passed++;
        checks++; if (round_winner !== 2'd0) $display("FAIL next_winner_clear: got %0d want 0", round_winner); else passed++;
        checks++; if (health_rst !== 1'b1) $display("FAIL next_health_rst: got %0b want 1", health_rst); else passed++;
    endtask

    task automatic test_match_win;
        health_2 = 9'd0;
        step(3);
        checks++; if (phase !== 3'd1) $display("FAIL intro_ignores_health: got %0d want 1", phase); else passed++;
        step(1);
        checks++; if (phase !== 3'd2) $display("FAIL r2_fight: got %0d want 2", phase); else passed++;
        step(1);
        checks++; if (phase !== 3'd3) $display("FAIL r2_ko: got %0d want 3", phase); else passed++;
        checks++; if (wins_1 !== 2'd2) $display("FAIL r2_wins_1: got %0d want 2", wins_1); else passed++;
        health_2 = 9'd300;
        step(4);
        checks++; if (phase !== 3'd4) $display("FAIL match_over: got %0d want 4", phase); else passed++;
        checks++; if (match_winner !== 2'd1) $display("FAIL match_winner_p1: got %0d want 1", match_winner); else passed++;
        checks++; if (round_num !== 3'd2) $display("FAIL match_round: got %0d want 2", round_num); else passed++;
    endtask

    task automatic test_timeout;
        start = 1'b1;
        step(1);
        checks++; if (phase !== 3'd1) $display("FAIL rematch_phase: got %0d want 1", phase); else passed++;
        checks++; if ({round_num, wins_1, wins_2, match_winner} !== 9'b001_00_00_00)
            $display("FAIL rematch_clear: got %b want 001000000", {round_num, wins_1, wins_2, match_winner}); else passed++;
        start = 1'b0;
        health_1 = 9'd150;
        health_2 = 9'd150;
        step(4);
        checks++; if (phase !== 3'd2) $display("FAIL to_fight: got %0d want 2", phase); else passed++;
        step(4);
        checks++; if (time_left !== 7'd2) $display("FAIL to_time_2: got %0d want 2", time_left); else passed++;
        step(8);
        checks++; if (phase !== 3'd2 || time_left !== 7'd0)
            $display("FAIL to_zero: got phase %0d time %0d want 2 0", phase, time_left); else passed++;
        step(1);
`ifdef SUDDEN_DEATH_EN
        checks++; if (phase !== 3'd2) $display("FAIL sd_continues: got %0d want 2", phase); else passed++;
        step(4);
        checks++; if (phase !== 3'd2 || time_left !== 7'd0)
            $display("FAIL sd_hold: got phase %0d time %0d want 2 0", phase, time_left); else passed++;
        health_1 = 9'd140;
        step(1);
        checks++; if (phase !== 3'd3) $display("FAIL sd_end: got %0d want 3", phase); else passed++;
        checks++; if (round_winner !== 2'd2) $display("FAIL sd_winner: got %0d want 2", round_winner); else passed++;
        checks++; if (wins_2 !== 2'd1) $display("FAIL sd_wins_2: got %0d want 1", wins_2); else passed++;
`else
        checks++; if (phase !== 3'd3) $display("FAIL to_end: got %0d want 3", phase); else passed++;
        checks++; if (round_winner !== 2'd3) $display("FAIL to_draw: got %0d want 3", round_winner); else passed++;
        checks++; if ({wins_1, wins_2} !== 4'd0) $display("FAIL to_no_wins: got %b want 0000", {wins_1, wins_2}); else passed++;
`endif
        health_1 = 9'd300;
        health_2 = 9'd300;
    endtask

    task automatic test_draws;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++; if (phase !== 3'd1) $display("FAIL draws_intro: got %0d want 1", phase); else passed++;
        for (int r = 1; r <= 5; r++) begin
            step(4);
            checks++; if (phase !== 3'd2 || round_num !== 3'(r))
                $display("FAIL draws_fight: got phase %0d round %0d want 2 %0d", phase, round_num, r); else passed++;
            health_1 = 9'd0;
            health_2 = 9'd0;
            step(1);
            checks++; if (phase !== 3'd3 || round_winner !== 2'd3)
                $display("FAIL draws_double_ko: got phase %0d winner %0d want 3 3", phase, round_winner); else passed++;
            health_1 = 9'd300;
            health_2 = 9'd300;
            step(4);
            if (r < 5) begin
                checks++; if (phase !== 3'd1) $display("FAIL draws_next: got %0d want 1", phase); else passed++;
            end
        end
        checks++; if (phase !== 3'd4) $display("FAIL draws_over: got %0d want 4", phase); else passed++;
        checks++; if (match_winner !== 2'd3) $display("FAIL draws_match_winner: got %0d want 3", match_winner); else passed++;
        checks++; if (round_num !== 3'd5 || {wins_1, wins_2} !== 4'd0)
            $display("FAIL draws_counts: got round %0d wins %b want 5 0000", round_num, {wins_1, wins_2}); else passed++;
    endtask

    task automatic test_ignore_and_abort;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        checks++; if (phase !== 3'd2) $display("FAIL abort_fight: got %0d want 2", phase); else passed++;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        checks++; if (phase !== 3'd2 || round_num !== 3'd1)
            $display("FAIL start_ignored: got phase %0d round %0d want 2 1", phase, round_num); else passed++;
        reset = 1'b1;
        step(1);
        checks++; if (phase !== 3'd0) $display("FAIL abort_phase: got %0d want 0", phase); else passed++;
        checks++; if (health_rst !== 1'b1) $display("FAIL abort_health_rst: got %0b want 1", health_rst); else passed++;
        checks++; if ({fight_en, round_num, wins_1, wins_2, time_left, round_winner, match_winner} !== 19'd0)
            $display("FAIL abort_outputs: got %h want 0", {fight_en, round_num, wins_1, wins_2, time_left, round_winner, match_winner}); else passed++;
        reset = 1'b0;
        step(1);
        checks++; if (health_rst !== 1'b0 || phase !== 3'd0)
            $display("FAIL abort_release: got rst %0b phase %0d want 0 0", health_rst, phase); else passed++;
    endtask

    task automatic test_p2_ko;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        health_1 = 9'd0;
        step(1);
        checks++; if (phase !== 3'd3 || round_winner !== 2'd2)
            $display("FAIL p2_ko: got phase %0d winner %0d want 3 2", phase, round_winner); else passed++;
        checks++; if (wins_2 !== 2'd1 || wins_1 !== 2'd0)
            $display("FAIL p2_wins: got %0d/%0d want 0/1", wins_1, wins_2); else passed++;
        health_1 = 9'd300;
    endtask

    initial begin
        test_reset();
        test_start();
        test_ko();
        test_match_win();
        test_timeout();
        test_draws();
        test_ignore_and_abort();
        test_p2_ko();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer for the health datapath: pulses the health block's reset, gates fighting, runs the round clock, and detects KO or timeout.
- Tracks round wins and declares the match winner; best-of-N rounds.
- Sits between the top-level button logic and the health block; its outputs drive the HUD and the input-gating logic.

Parameters:
- TICKS_PER_SEC, 100000000: clk cycles per game second.
- INTRO_SECS, 3: countdown length before each round.
- ROUND_SECS, 60: round clock start value, at most 127.
- KO_HOLD_SECS, 2: freeze time after a round ends.
- WINS_TO_MATCH, 2: round wins needed to take the match, 1..3.
- MAX_ROUNDS, 5: hard round cap, 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level button input; rising edge detected internally.
- health_1  in  9  player-1 health from the health block.
- health_2  in  9  player-2 health from the health block.
- health_rst  out  1  one-cycle pulse; refills both healths.
- fight_en  out  1  high only in FIGHT; gates movement and attacks.
- phase  out  3  0=IDLE, 1=INTRO, 2=FIGHT, 3=ROUND_END, 4=MATCH_OVER.
- round_num  out  3  current round, 1-based; 0 in IDLE.
- wins_1  out  2  player-1 round wins.
- wins_2  out  2  player-2 round wins.
- time_left  out  7  round seconds remaining.
- round_winner  out  2  0=none, 1=P1, 2=P2, 3=draw.
- match_winner  out  2  same encoding; valid in MATCH_OVER.

Behaviour:
- All state is registered; one always block per register group.
- Reset values: phase=IDLE; health_rst=1 for the reset cycle only; every other output 0.
- Tick counter:
  - Counts 0..TICKS_PER_SEC-1.
  - Cleared on every phase change.
  - sec_tick is high for one cycle at wrap.
  - sec_cnt counts sec_ticks within the current phase.
- IDLE: start rising edge leads to INTRO.
  - On that transition: round_num=1, wins cleared, round_winner=0, match_winner=0.
- INTRO:
  - health_rst is high for exactly the first cycle of INTRO.
  - time_left is loaded with ROUND_SECS.
  - After INTRO_SECS sec_ticks, go to FIGHT.
  - Health inputs are ignored in INTRO, which covers the health block's one-cycle registered latency.
- FIGHT:
  - fight_en=1.
  - Each sec_tick decrements time_left, saturating at 0.
  - Exit checks are made every cycle, first match wins:
    - (a) health_1==0 and health_2==0: draw.
    - (b) health_2==0: P1 wins the round.
    - (c) health_1==0: P2 wins the round.
    - (d) time_left==0: the higher health wins; equal health is a draw.
  - On exit: latch round_winner, increment the winner's wins (saturating at 3), go to ROUND_END.
  - Transition latency from the KO or timeout condition is 1 cycle.
- ROUND_END:
  - fight_en=0.
  - After KO_HOLD_SECS sec_ticks:
    - If wins_1 or wins_2 == WINS_TO_MATCH, or round_num == MAX_ROUNDS, go to MATCH_OVER.
    - Otherwise round_num+1, round_winner=0, go to INTRO.
- MATCH_OVER:
  - match_winner = player with more wins; equal wins is a draw (3).
  - A start rising edge goes to INTRO with round 1 and all counters cleared, as from IDLE.
- Start edges are ignored outside IDLE and MATCH_OVER.
- Reset mid-round aborts immediately to IDLE and pulses health_rst.

Optional Feature:
- Macro: SUDDEN_DEATH_EN.
- Defined:
  - A timeout with equal health, and no KO, does not end the round.
  - The FIGHT clock stops at 0 and the round continues.
  - Any further health difference ends it: the player with more health wins.
  - A simultaneous double KO is still a draw.
- Undefined: an equal-health timeout is a draw, as specified above.

Decomposition:
- Shared package holds:
  - Phase encodings.
  - Winner encodings (NONE, P1, P2, DRAW).
  - Health width 9.
- One natural sub-module: sec_timer.
  - Tick divider plus seconds counter.
  - Inputs: clear, enable.
  - Outputs: sec_tick, sec_cnt.

Test Plan:
All scenarios use TICKS_PER_SEC=4, INTRO_SECS=1, ROUND_SECS=3, KO_HOLD_SECS=1.
- Start edge from IDLE -> health_rst high exactly 1 cycle; phase=INTRO; after 4 cycles phase=FIGHT, time_left=3, fight_en=1.
- In FIGHT drive health_2=0, health_1=200 -> next cycle phase=ROUND_END, round_winner=1, wins_1=1, fight_en=0.
- Both healths at 150 through timeout -> after 12 FIGHT cycles round_winner=3, no wins incremented; with SUDDEN_DEATH_EN, phase stays FIGHT until health_1=140, then round_winner=2.
- P1 wins rounds 1 and 2 -> after second ROUND_END hold, phase=MATCH_OVER, match_winner=1, round_num=2.
- Five draw rounds -> MATCH_OVER after round 5 with match_winner=3.
- Assert reset mid-FIGHT -> next cycle phase=IDLE, all outputs 0, health_rst pulsed; start pressed during FIGHT is ignored.
